// File: rtl/onewire_pkg.sv
// Shared definitions for the byte-level 1-Wire master: op codes, FSM states
// and slot timing expressed in 0.25 us ticks.
package onewire_pkg;

  localparam int CNT_W = 12;

  typedef enum logic [1:0] {
    OP_RESET = 2'd0,
    OP_WRITE = 2'd1,
    OP_READ  = 2'd2,
    OP_RSVD  = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST_LOW,
    S_RST_WAIT,
    S_RST_REC,
    S_SLOT_LOW,
    S_SLOT_REL,
    S_RSP
  } state_t;

  // Reset-pulse points are counted from bus release; slot points from slot start.
  typedef struct packed {
    logic [CNT_W-1:0] rst_low;
    logic [CNT_W-1:0] rst_pres;
    logic [CNT_W-1:0] rst_end;
    logic [CNT_W-1:0] slot_low1;
    logic [CNT_W-1:0] slot_low0;
    logic [CNT_W-1:0] slot_samp;
    logic [CNT_W-1:0] slot_end;
  } timing_t;

  localparam timing_t T_STD = '{rst_low: 12'd1920, rst_pres: 12'd280, rst_end: 12'd1920,
                                slot_low1: 12'd24, slot_low0: 12'd240, slot_samp: 12'd60,
                                slot_end: 12'd280};
  localparam timing_t T_OD  = '{rst_low: 12'd280, rst_pres: 12'd34, rst_end: 12'd280,
                                slot_low1: 12'd4, slot_low0: 12'd30, slot_samp: 12'd8,
                                slot_end: 12'd40};

  function automatic timing_t timing_sel(input logic od);
    return od ? T_OD : T_STD;
  endfunction

endpackage

// File: rtl/onewire_if.sv
// Command/response port of the 1-Wire master, seen from the software front end.
interface onewire_if;

  // Both channels are valid/ready: a transfer happens on a clock edge where
  // valid && ready are both high; valid and payload stay stable until then.
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_pres;

  modport master (
    output cmd_valid, cmd_op, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_pres
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_pres
  );

endinterface

// File: rtl/onewire_tick_gen.sv
// Timing-tick prescaler: one-cycle tick every TICK_DIV clocks, restartable by clr.
module onewire_tick_gen #(
  parameter int TICK_DIV = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr || cnt == LAST) cnt <= '0;
    else                           cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/onewire_master.sv
// Byte-level 1-Wire master: reset/presence, write-byte and read-byte slots on an
// open-drain line (o_data 0 = pull low, 1 = release).
module onewire_master
  import onewire_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int TICK_HZ     = 4_000_000
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      FS,
  onewire_if.slave  cmd,
  output logic      busy,
  input  logic      i_data,
  output logic      o_data,
  output state_t    dbg_state
);

  localparam int TICK_DIV = CLK_FREQ_HZ / TICK_HZ;

  state_t           state, state_next;
  logic [CNT_W-1:0] phase, phase_next, phase_inc;
  logic [2:0]       bit_cnt, bit_next;
  logic [7:0]       tx_q;
  logic [7:0]       shift_q, shift_next;
  logic             pres_q, pres_next;
  logic             od_q;
  logic             sync_1, sync_i;
  logic             tick, accept, slot_sample;
  logic [CNT_W-1:0] slot_low;
  timing_t          tm;

  assign cmd.cmd_ready = (state == S_IDLE) && !rst;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;

  onewire_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .tick (tick)
  );

  assign tm          = timing_sel(od_q);
  assign phase_inc   = phase + 1'b1;
  assign slot_low    = tx_q[bit_cnt] ? tm.slot_low1 : tm.slot_low0;
  // A 0-bit is still held low at the sample point, so sampling covers both slot phases.
  assign slot_sample = tick && (phase_inc == tm.slot_samp) &&
                       (state == S_SLOT_LOW || state == S_SLOT_REL);

  always_comb begin
    state_next = state;
    phase_next = phase;
    bit_next   = bit_cnt;
    shift_next = slot_sample ? {sync_i, shift_q[7:1]} : shift_q;
    pres_next  = pres_q;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_next = (cmd.cmd_op == OP_WRITE || cmd.cmd_op == OP_READ) ? S_SLOT_LOW : S_RST_LOW;
          phase_next = '0;
          bit_next   = '0;
          shift_next = '0;
          pres_next  = 1'b0;
        end
      end
      S_RST_LOW: begin
        if (tick) begin
          phase_next = phase_inc;
          if (phase_inc == tm.rst_low) begin
            state_next = S_RST_WAIT;
            phase_next = '0;
          end
        end
      end
      S_RST_WAIT: begin
        if (tick) begin
          phase_next = phase_inc;
          if (phase_inc == tm.rst_pres) begin
            pres_next  = ~sync_i;
            state_next = S_RST_REC;
          end
        end
      end
      S_RST_REC: begin
        if (tick) begin
          phase_next = phase_inc;
          if (phase_inc == tm.rst_end) begin
            state_next = S_RSP;
            phase_next = '0;
          end
        end
      end
      S_SLOT_LOW: begin
        if (tick) begin
          phase_next = phase_inc;
          if (phase_inc == slot_low) state_next = S_SLOT_REL;
        end
      end
      S_SLOT_REL: begin
        if (tick) begin
          phase_next = phase_inc;
          if (phase_inc == tm.slot_end) begin
            phase_next = '0;
            if (bit_cnt == 3'd7) begin
              state_next = S_RSP;
            end else begin
              bit_next   = bit_cnt + 1'b1;
              state_next = S_SLOT_LOW;
            end
          end
        end
      end
      S_RSP: begin
        if (cmd.rsp_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      phase   <= '0;
      bit_cnt <= '0;
      shift_q <= '0;
      pres_q  <= 1'b0;
      tx_q    <= '0;
      od_q    <= 1'b0;
      o_data  <= 1'b1;
      sync_1  <= 1'b1;
      sync_i  <= 1'b1;
    end else begin
      state   <= state_next;
      phase   <= phase_next;
      bit_cnt <= bit_next;
      shift_q <= shift_next;
      pres_q  <= pres_next;
      sync_1  <= i_data;
      sync_i  <= sync_1;
      o_data  <= !(state_next == S_RST_LOW || state_next == S_SLOT_LOW);
      if (accept) begin
        tx_q <= (cmd.cmd_op == OP_WRITE) ? cmd.cmd_data : 8'hFF;
        od_q <= FS;
      end
    end
  end

  assign cmd.rsp_valid = (state == S_RSP);
  assign cmd.rsp_data  = shift_q;
  assign cmd.rsp_pres  = pres_q;
  assign busy          = (state != S_IDLE);
  assign dbg_state     = state;

endmodule

// File: tb/tb_onewire_master.sv
// Directed plus random bench for onewire_master with a pull-up bus and a slave
// model; the clock is scaled so one timing tick is two clocks.
module tb_onewire_master;
  import onewire_pkg::*;

  localparam int CLK_PERIOD = 10;
  localparam int TD         = 2;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  logic   FS  = 1'b0;
  logic   i_data, o_data, busy;
  state_t dbg_state;
  logic   slave_n = 1'b1;

  onewire_if ow ();

  assign i_data = o_data & slave_n;

  onewire_master #(.CLK_FREQ_HZ(8_000_000), .TICK_HZ(4_000_000)) dut (
    .clk       (clk),
    .rst       (rst),
    .FS        (FS),
    .cmd       (ow),
    .busy      (busy),
    .i_data    (i_data),
    .o_data    (o_data),
    .dbg_state (dbg_state)
  );

  always #(CLK_PERIOD/2) clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [8:0]  exp_q[$];
  int          exp_low_q[$];
  int          low_q[$];
  time         fall_q[$];
  time         t_acc;

  int          slave_mode = 0;
  logic        slave_fs   = 1'b0;
  logic [7:0]  slave_pat  = 8'hFF;
  int          slave_idx  = 0;

  // Records every low pulse the master drives.
  initial begin
    time tf;
    forever begin
      @(negedge o_data);
      tf = $time;
      fall_q.push_back(tf);
      @(posedge o_data);
      low_q.push_back(int'(($time - tf) / CLK_PERIOD));
    end
  end

  // Slave: mode 1 answers a reset with presence, mode 2 returns slave_pat on read slots.
  initial begin
    forever begin
      @(negedge o_data);
      if (slave_mode == 1) begin
        @(posedge o_data);
        repeat ((slave_fs ? 8 : 60) * TD) @(posedge clk);
        slave_n = 1'b0;
        repeat ((slave_fs ? 32 : 480) * TD) @(posedge clk);
        slave_n = 1'b1;
      end else if (slave_mode == 2) begin
        if (!slave_pat[slave_idx[2:0]]) begin
          slave_n = 1'b0;
          repeat ((slave_fs ? 16 : 120) * TD) @(posedge clk);
          slave_n = 1'b1;
        end
        slave_idx++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] data, input logic fs);
    int n = 0;
    @(negedge clk);
    while (ow.cmd_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_wait", {31'd0, ow.cmd_ready}, 32'd1);
    ow.cmd_valid = 1'b1;
    ow.cmd_op    = op;
    ow.cmd_data  = data;
    FS           = fs;
    @(posedge clk);
    t_acc = $time;
    @(negedge clk);
    ow.cmd_valid = 1'b0;
    ow.cmd_data  = 8'($urandom);
    FS           = ~fs;
  endtask

  task automatic wait_rsp(input int limit, output int lat);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ow.rsp_valid !== 1'b1 && n < limit);
    lat = int'(($time - CLK_PERIOD/2 - t_acc) / CLK_PERIOD);
  endtask

  task automatic take_rsp(input string tag);
    ow.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ow.rsp_ready = 1'b0;
    check({tag, "_after_rsp"}, {28'd0, ow.rsp_valid, ow.cmd_ready, busy, o_data}, 32'b0101);
  endtask

  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [7:0] data,
                         input logic fs, input logic pres_on, input logic [7:0] pat);
    bit         is_slot;
    bit         one;
    int         slot_t, exp_lat, lat;
    logic [8:0] expv;
    is_slot = (op == 2'd1 || op == 2'd2);
    slot_t  = fs ? 40 : 280;
    exp_low_q.delete();
    low_q.delete();
    fall_q.delete();
    if (!is_slot) begin
      exp_q.push_back({pres_on, 8'h00});
      exp_low_q.push_back((fs ? 280 : 1920) * TD);
      exp_lat = 2 * (fs ? 280 : 1920) * TD;
    end else begin
      for (int b = 0; b < 8; b++) begin
        one = (op == 2'd2) ? 1'b1 : data[b];
        exp_low_q.push_back((one ? (fs ? 4 : 24) : (fs ? 30 : 240)) * TD);
      end
      exp_q.push_back({1'b0, (op == 2'd2) ? pat : data});
      exp_lat = 8 * slot_t * TD;
    end
    slave_fs   = fs;
    slave_pat  = pat;
    slave_idx  = 0;
    slave_mode = !is_slot ? (pres_on ? 1 : 0) : ((op == 2'd2) ? 2 : 0);

    issue(op, data, fs);
    wait_rsp(exp_lat + 100, lat);
    checks++;
    assert (ow.rsp_valid === 1'b1 && lat >= exp_lat - 3 && lat <= exp_lat + 3) else begin
      errors++;
      $error("FAIL %s_latency: got %0d cycles (valid=%b) expected %0d", tag, lat, ow.rsp_valid, exp_lat);
    end
    expv = exp_q.pop_front();
    check({tag, "_rsp"}, {23'd0, ow.rsp_pres, ow.rsp_data}, {23'd0, expv});
    check({tag, "_nlow"}, low_q.size(), exp_low_q.size());
    for (int i = 0; i < exp_low_q.size() && i < low_q.size(); i++)
      check($sformatf("%s_low%0d", tag, i), low_q[i], exp_low_q[i]);
    check({tag, "_start"}, (fall_q.size() > 0) ? 32'(fall_q[0] - t_acc) : 32'hFFFF_FFFF, 32'd0);
    if (is_slot)
      for (int i = 1; i < fall_q.size(); i++)
        check($sformatf("%s_period%0d", tag, i), 32'((fall_q[i] - fall_q[i-1]) / CLK_PERIOD),
              32'(slot_t * TD));
    take_rsp(tag);
  endtask

  initial begin
    int         lat;
    bit         ok;
    logic [7:0] held;
    int         nfall;
    ow.cmd_valid = 1'b0;
    ow.cmd_op    = 2'd0;
    ow.cmd_data  = 8'd0;
    ow.rsp_ready = 1'b0;

    // Reset state
    repeat (4) @(negedge clk);
    check("reset_outputs", {21'd0, ow.cmd_ready, ow.rsp_valid, busy, o_data, ow.rsp_pres, ow.rsp_data},
          {21'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00});
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", {28'd0, ow.cmd_ready, 3'(dbg_state)}, {28'd0, 1'b1, 3'(S_IDLE)});

    run_cmd("rst_std", 2'd0, 8'h00, 1'b0, 1'b1, 8'hFF);
    run_cmd("rst_od", 2'd0, 8'h00, 1'b1, 1'b0, 8'hFF);
    run_cmd("wr_a5", 2'd1, 8'hA5, 1'b0, 1'b0, 8'hFF);
    run_cmd("rd_3c", 2'd2, 8'h00, 1'b1, 1'b0, 8'h3C);

    // Response back-pressure with a command waiting
    slave_mode = 0;
    issue(2'd1, 8'h5A, 1'b1);
    wait_rsp(8 * 40 * TD + 100, lat);
    check("bp_rsp", {23'd0, ow.rsp_valid, ow.rsp_data}, {23'd0, 1'b1, 8'h5A});
    held  = ow.rsp_data;
    nfall = fall_q.size();
    ow.cmd_valid = 1'b1;
    ow.cmd_op    = 2'd0;
    FS           = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ow.rsp_valid !== 1'b1 || ow.rsp_data !== held || ow.cmd_ready !== 1'b0 || o_data !== 1'b1)
        ok = 1'b0;
    end
    check("bp_hold_stable", {31'd0, ok}, 32'd1);
    check("bp_no_bus_activity", fall_q.size(), nfall);
    ow.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ow.rsp_ready = 1'b0;
    check("bp_handshake_edge", {28'd0, ow.rsp_valid, ow.cmd_ready, busy, o_data}, 32'b0101);
    @(posedge clk);
    t_acc = $time;
    @(negedge clk);
    ow.cmd_valid = 1'b0;
    check("bp_next_accept", {30'd0, busy, o_data}, 32'b10);
    wait_rsp(2 * 280 * TD + 100, lat);
    check("bp_reset_lat", lat, 2 * 280 * TD);
    check("bp_reset_rsp", {23'd0, ow.rsp_pres, ow.rsp_data}, 32'd0);
    take_rsp("bp_reset");

    // Reset asserted in the middle of a low phase
    issue(2'd1, 8'h00, 1'b0);
    repeat (50) @(negedge clk);
    check("midslot_low", {29'd0, o_data, 3'(dbg_state)}, {29'd0, 1'b0, 3'(S_SLOT_LOW)});
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midslot_release", {29'd0, o_data, busy, ow.cmd_ready}, 32'b100);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midslot_ready", {31'd0, ow.cmd_ready}, 32'd1);
    run_cmd("rst_after", 2'd0, 8'h00, 1'b0, 1'b1, 8'hFF);

    // Random commands against the reference model
    for (int k = 0; k < 5; k++) begin
      logic [1:0] op;
      logic [7:0] d, p;
      logic       f, pr;
      op = 2'($urandom_range(0, 3));
      d  = 8'($urandom);
      p  = 8'($urandom);
      f  = 1'($urandom_range(0, 1));
      pr = 1'($urandom_range(0, 1));
      run_cmd($sformatf("rand%0d", k), op, d, f, pr, p);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
